// File: rtl/pipelined_carry_select_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_carry_select_adder_if
//
// Purpose : Operand/result bundle for pipelined_carry_select_adder. It groups
//           the input handshake (in_valid/in_ready), the operands, the
//           operation controls, the output handshake (out_valid/out_ready)
//           and the result fields.
//
// Parameters:
//   WIDTH      operand and result width in bits.
//
// Signals:
//   in_valid   producer -> adder   operands valid this cycle
//   in_ready   adder -> producer   adder accepts operands this cycle
//   a, b       producer -> adder   operands (WIDTH bits)
//   cin        producer -> adder   carry in (ignored when sub=1)
//   sub        producer -> adder   0: a+b+cin, 1: a-b
//   out_valid  adder -> consumer   result fields valid
//   out_ready  consumer -> adder   consumer takes the result
//   s          adder -> consumer   sum / difference (WIDTH bits)
//   cout       adder -> consumer   carry out of the MSB (sub: 1 = no borrow)
//   ovf        adder -> consumer   signed overflow
//   zf         adder -> consumer   s == 0
//
// Modports:
//   slave      the adder's view
//   master     the surrounding datapath's (or bench's) view
// ---------------------------------------------------------------------------
interface pipelined_carry_select_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zf
    );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_select_adder
//
// Purpose : Parametrised, pipelined carry-select adder/subtractor with signed
//           overflow and zero flags. Each BLK-bit carry-select block has its
//           own pipeline register, followed by one result register that also
//           forms the flags. An operation accepted at edge t is presented
//           at edge t+NSTG. One global enable stalls the whole pipeline
//           when the result register is full and the consumer is not ready.
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of BLK (default 32)
//   BLK    bits per carry-select block / pipeline stage (default 8)
//   NSTG   derived = WIDTH/BLK, latency in cycles
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   bus    pipelined_carry_select_adder_if.slave
//          (in_valid/in_ready, a, b, cin, sub,
//           out_valid/out_ready, s, cout, ovf, zf)
//
// Optional build macro:
//   PCSA_SATURATE_EN  when defined, an overflowing result is clamped to
//                     the signed limit (ovf/cout still report the raw
//                     event, zf is taken on the clamped value). When not
//                     defined, s is the wrapped two's-complement result
//                     and no clamp logic exists.
// ---------------------------------------------------------------------------
module pipelined_carry_select_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input logic                            clk,
    input logic                            rst,
    pipelined_carry_select_adder_if.slave  bus
);

    localparam int NSTG = WIDTH / BLK;

    // -----------------------------------------------------------------------
    // Elaboration-time legality check
    // -----------------------------------------------------------------------
    generate
        if ((BLK < 1) || (WIDTH < BLK) || ((WIDTH % BLK) != 0)) begin : g_illegal
            $error("pipelined_carry_select_adder: WIDTH (%0d) must be a non-zero multiple of BLK (%0d)",
                   WIDTH, BLK);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Pipeline stage registers. Each stage carries its valid bit, the
    // prepared operands (only the not-yet-consumed upper bits are read by
    // later stages), the partial sum built so far, the block carry and the
    // operand sign bits needed for the overflow flag at the end.
    // -----------------------------------------------------------------------
    logic             v_q   [NSTG];
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];
    logic [WIDTH-1:0] sum_q [NSTG];
    logic             c_q   [NSTG];
    logic             sa_q  [NSTG];
    logic             sb_q  [NSTG];

    logic             v_d   [NSTG];
    logic [WIDTH-1:0] a_d   [NSTG];
    logic [WIDTH-1:0] b_d   [NSTG];
    logic [WIDTH-1:0] sum_d [NSTG];
    logic             c_d   [NSTG];
    logic             sa_d  [NSTG];
    logic             sb_d  [NSTG];

    // Stage inputs: stage 0 reads the prepared operands, stage k reads the
    // register of stage k-1.
    logic             src_v   [NSTG];
    logic [WIDTH-1:0] src_a   [NSTG];
    logic [WIDTH-1:0] src_b   [NSTG];
    logic [WIDTH-1:0] src_sum [NSTG];
    logic             src_c   [NSTG];
    logic             src_sa  [NSTG];
    logic             src_sb  [NSTG];

    // Selected block result per stage: {block carry out, BLK sum bits}
    logic [BLK:0]     blk_sel [NSTG];

    // Result register
    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zf_q;

    logic             en;
    logic [WIDTH-1:0] b_prep;

    // The whole pipeline moves together; it only holds when a finished
    // result is waiting on a consumer that is not ready.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    // -----------------------------------------------------------------------
    // Operand preparation and stage input routing
    // -----------------------------------------------------------------------
    always_comb begin
        // Subtraction is a + ~b + 1: invert b and force the carry in.
        b_prep = bus.sub ? ~bus.b : bus.b;

        src_v[0]   = bus.in_valid;
        src_a[0]   = bus.a;
        src_b[0]   = b_prep;
        src_c[0]   = bus.sub | bus.cin;
        src_sum[0] = '0;
        src_sa[0]  = bus.a[WIDTH-1];
        src_sb[0]  = b_prep[WIDTH-1];

        for (int k = 1; k < NSTG; k++) begin
            src_v[k]   = v_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_c[k]   = c_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_sa[k]  = sa_q[k-1];
            src_sb[k]  = sb_q[k-1];
        end
    end

    // -----------------------------------------------------------------------
    // Carry-select blocks: both candidate sums are formed in parallel and
    // the registered carry from the stage below only drives a mux.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_blk
            logic [BLK:0] sum_c0;
            logic [BLK:0] sum_c1;

            assign sum_c0 = {1'b0, src_a[gi][gi*BLK +: BLK]}
                          + {1'b0, src_b[gi][gi*BLK +: BLK]};
            // Cannot overflow BLK+1 bits: the largest c0 sum is 2^(BLK+1)-2.
            assign sum_c1 = sum_c0 + {{BLK{1'b0}}, 1'b1};

            assign blk_sel[gi] = src_c[gi] ? sum_c1 : sum_c0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state of every stage: pass everything along and drop this
    // stage's block result into its slice of the partial sum.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            v_d[k]                 = src_v[k];
            a_d[k]                 = src_a[k];
            b_d[k]                 = src_b[k];
            sa_d[k]                = src_sa[k];
            sb_d[k]                = src_sb[k];
            sum_d[k]               = src_sum[k];
            sum_d[k][k*BLK +: BLK] = blk_sel[k][BLK-1:0];
            c_d[k]                 = blk_sel[k][BLK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                sa_q[k]  <= 1'b0;
                sb_q[k]  <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k]   <= v_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= c_d[k];
                sa_q[k]  <= sa_d[k];
                sb_q[k]  <= sb_d[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Flag formation and result register
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] wrap_s;
    logic [WIDTH-1:0] fin_s;
    logic             fin_ovf;
    logic             out_valid_d;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zf_d;

    assign wrap_s  = sum_q[NSTG-1];
    // Same-signed operands producing a result of the other sign.
    assign fin_ovf = (sa_q[NSTG-1] == sb_q[NSTG-1])
                  && (wrap_s[WIDTH-1] != sa_q[NSTG-1]);

`ifdef PCSA_SATURATE_EN
    // On overflow both operands share sign sa: clamp to the limit on that
    // side (sa=0 -> 0111..1, sa=1 -> 1000..0).
    assign fin_s = fin_ovf ? {sa_q[NSTG-1], {(WIDTH-1){~sa_q[NSTG-1]}}} : wrap_s;
`else
    assign fin_s = wrap_s;
`endif

    always_comb begin
        out_valid_d = v_q[NSTG-1];
        s_d         = fin_s;
        cout_d      = c_q[NSTG-1];
        ovf_d       = fin_ovf;
        zf_d        = (fin_s == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zf_q        <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zf_q        <= zf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zf        = zf_q;

    // A presented result that is not taken must stay put until it is.
    a_hold_when_stalled : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid_q && !bus.out_ready)
            |=> (out_valid_q && $stable(s_q) && $stable(cout_q)
                 && $stable(ovf_q) && $stable(zf_q))
    );

endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined successor to the fixed 32-bit carry-select adder used by the processor datapath.
- Operand width and block size are configurable. Each carry-select block gets its own pipeline stage, so the adder sustains one operation per cycle at high clock rate.
- Adds add/subtract mode, signed overflow and zero flags, and valid/ready handshakes on input and output with global backpressure stall.
- Sits between the operand-fetch stage and ALU writeback.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of BLK.
- BLK, 8, bits per carry-select block; one pipeline stage per block.
- NSTG, WIDTH/BLK (derived localparam, not overridable), number of stages = latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a/b/cin/sub valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; used only when sub=0.
- sub  input  1  0: s=a+b+cin; 1: s=a+~b+1 (a-b).
- out_valid  output  1  result fields valid.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow.
- zf  output  1  s == 0, evaluated on the final (possibly saturated) value.

Behaviour:
- One clock (clk); reset rst is synchronous, active-high. All state changes happen on the rising edge of clk.
- Reset: every stage valid bit, out_valid, s, cout, ovf and zf are cleared to 0. in_ready is 1 in the first cycle after reset.
- Global enable: en = !out_valid || out_ready, and in_ready = en.
  - When en=0, every pipeline register holds.
  - When en=1, all stages advance one position.
  - No bubble collapsing.
- Transfer in: occurs when in_valid && in_ready.
  - If in_valid=0 while en=1, a bubble (valid=0) enters stage 0.
- Subtract handling at stage 0 entry: b is replaced by ~b and the carry in is forced to 1 when sub=1; cin is ignored in that case.
- Stage k (k=0..NSTG-1):
  - Takes bits [k*BLK +: BLK] of the prepared operands.
  - Computes two BLK-bit sums, one with carry-in 0 and one with carry-in 1.
  - Selects between them using the registered carry from stage k-1 (stage 0 uses the prepared cin).
  - Registers the selected partial sum and the block carry-out.
- Skewing: operand bits not yet consumed, the already-computed lower sum bits, and the operand sign bits travel with each stage's valid bit.
- Latency: a result accepted at edge t is presented at edge t+NSTG, provided no stall occurs; each stall cycle adds one.
  - Throughput is 1 result/cycle when out_ready is held at 1.
- Final stage outputs:
  - s = concatenated partial sums.
  - cout = carry out of the MSB block.
  - ovf = (sA == sB') && (s[WIDTH-1] != sA), where sA and sB' are the sign bits of a and the prepared b.
  - zf = (s == 0).
- Output hold: s, cout, ovf and zf stay stable while out_valid && !out_ready. When out_valid=0 their values are don't-care, but they must not be X after reset.
- Order: results emerge strictly in acceptance order. No result is dropped or duplicated under any out_ready pattern.
- Reset mid-operation: all in-flight operations are discarded. The cycle after rst, out_valid=0, and no stale result ever appears.
- Simultaneous events: accept and emit in the same cycle are permitted when en=1.
- Legality: WIDTH % BLK != 0 is illegal and is caught by a generate-time $error.

Optional Feature:
- Macro: PCSA_SATURATE_EN.
- Defined: when ovf=1, s is clamped to the signed limit.
  - Positive overflow gives 0 followed by all 1s (32'h7FFFFFFF).
  - Negative overflow gives 1 followed by all 0s (32'h80000000).
  - ovf and cout still report the unclamped event.
  - zf is computed on the clamped s.
- Undefined: s is the wrapped two's-complement result, and no clamp logic is synthesised.

Test Plan:
- Default params, out_ready=1; a=32'hB67A2A3D, b=32'hF0F0F0F0, cin=0, sub=0 → after 4 cycles s=32'hA76B1B2D, cout=1, ovf=0, zf=0.
- a=5, b=7, sub=1 → s=32'hFFFFFFFE, cout=0, ovf=0. Then a=7, b=7, sub=1 → s=0, zf=1, cout=1.
- a=32'h7FFFFFFF, b=1, sub=0 → ovf=1. Without macro s=32'h80000000; with PCSA_SATURATE_EN s=32'h7FFFFFFF, zf=0.
- Six back-to-back inputs with out_ready=0 for cycles 5–7 → in_ready=0 during the stall, s held stable, all six results delivered in order with none lost.
- Three operations in flight, assert rst for one cycle → out_valid=0 the next cycle, none of the three emerges, in_ready=1.
- WIDTH=16, BLK=4, random stimulus with a scoreboard (a±b) → latency exactly 4 cycles, every s/cout/ovf matches the model.
